// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rf_arb_pkg;

   localparam int REG_AW = 5;
   localparam int REG_DW = 32;

   // One queued register-file write: destination and data.
   typedef struct packed {
      logic [REG_AW-1:0] rw;
      logic [REG_DW-1:0] data;
   } wb_entry_t;

   // Which source owns the write port in a given cycle.
   typedef enum logic [1:0] {
      GNT_IDLE = 2'd0,
      GNT_PIPE = 2'd1,
      GNT_MDU  = 2'd2
   } grant_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Small circular buffer holding MDU results waiting for the write port.
// Latency: push visible at head one cycle later; no bypass.
// Backpressure: full_o refuses pushes; push when full or pop when empty is ignored.
module rf_wb_fifo
   import rf_arb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      push_i,
   input  wb_entry_t                 push_entry_i,
   input  logic                      pop_i,
   output logic                      full_o,
   output logic                      empty_o,
   output wb_entry_t                 head_o,
   output logic [DEPTH-1:0]          ent_vld_o,
   output logic [DEPTH*REG_AW-1:0]   ent_rw_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   wb_entry_t        mem_q [DEPTH];
   logic [DEPTH-1:0] vld_q, vld_d;
   logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign full_o    = (cnt_q == FULL_CNT);
   assign empty_o   = (cnt_q == '0);
   assign do_push   = push_i && !full_o;
   assign do_pop    = pop_i && !empty_o;
   assign head_o    = mem_q[rd_q];
   assign ent_vld_o = vld_q;

   // Flatten stored destinations so the pending match can see every slot.
   always_comb begin
      ent_rw_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         ent_rw_o[i*REG_AW +: REG_AW] = mem_q[i].rw;
      end
   end

   // Pointer, occupancy and per-slot valid next state; pointers wrap at DEPTH.
   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      vld_d = vld_q;
      if (do_pop) begin
         vld_d[rd_q] = 1'b0;
         rd_d        = (rd_q == LAST_PTR) ? '0 : rd_q + 1'b1;
      end
      if (do_push) begin
         vld_d[wr_q] = 1'b1;
         wr_d        = (wr_q == LAST_PTR) ? '0 : wr_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // Control state; reset flushes everything queued.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         vld_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
         vld_q <= vld_d;
      end
   end

   // Entry storage; contents only matter while the slot is marked valid.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_q] <= push_entry_i;
      end
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between the WB stage and buffered MDU results.
// Latency: pipe write registered in 1 cycle; MDU result at least 2 cycles (push, then pop).
// Backpressure: MduReady = !full && Run; PipeStall holds WB when the MDU head has starved.
module rf_wb_arbiter
   import rf_arb_pkg::*;
#(
   parameter int DEPTH  = 2,
   parameter int STARVE = 4
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              Run,
   input  logic              PipeWr,
   input  logic [REG_AW-1:0] PipeRw,
   input  logic [REG_DW-1:0] PipeBusW,
   input  logic              MduValid,
   input  logic [REG_AW-1:0] MduRw,
   input  logic [REG_DW-1:0] MduBusW,
   output logic              MduReady,
   output logic              PipeStall,
   input  logic [REG_AW-1:0] Rs,
   input  logic [REG_AW-1:0] Rt,
   output logic              RsPend,
   output logic              RtPend,
   output logic              RegWr,
   output logic [REG_AW-1:0] Rw,
   output logic [REG_DW-1:0] busW
);

   localparam int SW = $clog2(STARVE + 1);
   localparam logic [SW-1:0] STARVE_C = SW'(STARVE);

   logic                    fifo_full, fifo_empty, fifo_push, fifo_pop;
   wb_entry_t               fifo_head, push_entry;
   logic [DEPTH-1:0]        ent_vld;
   logic [DEPTH*REG_AW-1:0] ent_rw;
   logic                    pipe_req;
   grant_t                  grant;

   logic                    regwr_q, regwr_d;
   logic [REG_AW-1:0]       rw_q, rw_d;
   logic [REG_DW-1:0]       busw_q, busw_d;
   logic [SW-1:0]           starve_q, starve_d;

   assign pipe_req   = PipeWr && (PipeRw != '0);
   assign MduReady   = !fifo_full && Run;
   assign PipeStall  = !fifo_empty && (starve_q >= STARVE_C);
   // Writes to r0 are accepted from the MDU but never occupy a slot.
   assign fifo_push  = MduValid && MduReady && (MduRw != '0);
   assign fifo_pop   = Run && (grant == GNT_MDU);
   assign push_entry = '{rw: MduRw, data: MduBusW};

   rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i        (Clk),
      .rst_i        (Rst),
      .push_i       (fifo_push),
      .push_entry_i (push_entry),
      .pop_i        (fifo_pop),
      .full_o       (fifo_full),
      .empty_o      (fifo_empty),
      .head_o       (fifo_head),
      .ent_vld_o    (ent_vld),
      .ent_rw_o     (ent_rw)
   );

   // Grant: starved MDU head beats WB, WB beats a non-starved MDU head.
   always_comb begin
      grant = GNT_IDLE;
      if (PipeStall) begin
         grant = GNT_MDU;
      end else if (pipe_req) begin
         grant = GNT_PIPE;
      end else if (!fifo_empty) begin
         grant = GNT_MDU;
      end
   end

   // Output register and starvation counter next state.
   always_comb begin
      regwr_d  = 1'b0;
      rw_d     = rw_q;
      busw_d   = busw_q;
      starve_d = starve_q;
      case (grant)
         GNT_PIPE: begin
            regwr_d = 1'b1;
            rw_d    = PipeRw;
            busw_d  = PipeBusW;
         end
         GNT_MDU: begin
            regwr_d = 1'b1;
            rw_d    = fifo_head.rw;
            busw_d  = fifo_head.data;
         end
         default: ;
      endcase
      if (fifo_empty || (grant == GNT_MDU)) begin
         starve_d = '0;
      end else if (starve_q != STARVE_C) begin
         starve_d = starve_q + 1'b1;
      end
   end

   // State registers; Run=0 freezes, Rst wins over Run.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         regwr_q  <= 1'b0;
         rw_q     <= '0;
         busw_q   <= '0;
         starve_q <= '0;
      end else if (Run) begin
         regwr_q  <= regwr_d;
         rw_q     <= rw_d;
         busw_q   <= busw_d;
         starve_q <= starve_d;
      end
   end

   assign RegWr = regwr_q;
   assign Rw    = rw_q;
   assign busW  = busw_q;

   // Hazard query: queued entries plus the write sitting in the output register; r0 never pends.
   always_comb begin
      RsPend = 1'b0;
      RtPend = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_vld[i]) begin
            if (ent_rw[i*REG_AW +: REG_AW] == Rs) RsPend = 1'b1;
            if (ent_rw[i*REG_AW +: REG_AW] == Rt) RtPend = 1'b1;
         end
      end
      if (regwr_q && (rw_q == Rs)) RsPend = 1'b1;
      if (regwr_q && (rw_q == Rt)) RtPend = 1'b1;
      if (Rs == '0) RsPend = 1'b0;
      if (Rt == '0) RtPend = 1'b0;
   end

endmodule
